// File: rtl/vfp_sink_pkg.sv
// Shared types and checksum step for the RGB AXI4-Stream frame sink.
package vfp_sink_pkg;

    typedef enum logic [1:0] {SINK_IDLE, SINK_ACTIVE, SINK_DONE} sink_state_t;

    localparam int unsigned CHK_W = 32;

    function automatic logic [CHK_W-1:0] chk_step(input logic [CHK_W-1:0] chk,
                                                  input logic [CHK_W-1:0] pix);
        return {chk[CHK_W-2:0], chk[CHK_W-1]} ^ pix;
    endfunction

endpackage

// File: rtl/rgb_axis_frame_sink_if.sv
// AXI4-Stream video bus: tuser marks start of frame, tlast marks end of line.
interface rgb_axis_frame_sink_if #(
    parameter int unsigned DATA_W = 24
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tlast, output tuser, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tuser, input tdata, output tready);
endinterface

// File: rtl/rgb_sink_lfsr.sv
// Pseudo-random backpressure source: 16-bit Fibonacci LFSR (taps 16,14,13,11).
module rgb_sink_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] stall_thr,
    output logic       ok
);
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign ok = (lfsr[3:0] >= stall_thr);
endmodule

// File: rtl/rgb_axis_frame_sink.sv
// RGB AXI4-Stream frame sink: geometry tracking, SOF/EOL error counts, per-frame checksum.
// Optional LFSR backpressure is enabled by defining RGB_SINK_BACKPRESSURE_EN.
module rgb_axis_frame_sink
    import vfp_sink_pkg::*;
#(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned DIM_W     = 12,
    parameter int unsigned ERR_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   ACLK,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [DIM_W-1:0]       cfg_width,
    input  logic [DIM_W-1:0]       cfg_height,
    input  logic [3:0]             cfg_stall_thr,
    rgb_axis_frame_sink_if.slave   s_axis,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt,
    output logic [CHK_W-1:0]       frame_chksum,
    output logic [ERR_W-1:0]       err_sof_cnt,
    output logic [ERR_W-1:0]       err_eol_cnt,
    output logic                   busy
);
    sink_state_t      state, state_n;
    logic [DIM_W-1:0] x, x_n, y, y_n;
    logic [DIM_W-1:0] w_last, w_last_n, h_last, h_last_n;
    logic [DIM_W-1:0] w_cfg, h_cfg;
    logic [CHK_W-1:0] chk, chk_n, pix_ext;
    logic [DATA_W-1:0] pix;
    logic             beat, stall_ok, line_end;
    logic             sof_err, eol_err, finish;

`ifdef RGB_SINK_BACKPRESSURE_EN
    rgb_sink_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (ACLK),
        .reset     (reset),
        .stall_thr (cfg_stall_thr),
        .ok        (stall_ok)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_stall_thr, LFSR_SEED};
    assign stall_ok   = 1'b1;
`endif

    // Geometry stored as last index; width below 2 is forced to 2, height 0 to 1.
    assign w_cfg   = (cfg_width < DIM_W'(2)) ? DIM_W'(1) : cfg_width - DIM_W'(1);
    assign h_cfg   = (cfg_height == '0) ? '0 : cfg_height - DIM_W'(1);
    assign pix     = s_axis.tdata;
    assign pix_ext = CHK_W'(pix);

    assign s_axis.tready = enable & ~reset & (state != SINK_DONE) & stall_ok;
    assign beat          = s_axis.tvalid & s_axis.tready;
    assign busy          = (state == SINK_ACTIVE);

    always_comb begin
        state_n  = state;
        x_n      = x;
        y_n      = y;
        w_last_n = w_last;
        h_last_n = h_last;
        chk_n    = chk;
        sof_err  = 1'b0;
        eol_err  = 1'b0;
        finish   = 1'b0;
        line_end = (x == w_last);
        case (state)
            SINK_IDLE: begin
                if (beat) begin
                    if (s_axis.tuser) begin
                        state_n  = SINK_ACTIVE;
                        x_n      = DIM_W'(1);
                        y_n      = '0;
                        w_last_n = w_cfg;
                        h_last_n = h_cfg;
                        chk_n    = pix_ext;
                    end else begin
                        sof_err = 1'b1;
                    end
                end
            end
            SINK_ACTIVE: begin
                if (beat) begin
                    if (s_axis.tuser) begin
                        sof_err  = 1'b1;
                        x_n      = DIM_W'(1);
                        y_n      = '0;
                        w_last_n = w_cfg;
                        h_last_n = h_cfg;
                        chk_n    = pix_ext;
                    end else begin
                        chk_n   = chk_step(chk, pix_ext);
                        eol_err = (line_end != s_axis.tlast);
                        // A misplaced tlast still closes the line so the frame can finish.
                        if (line_end || s_axis.tlast) begin
                            x_n = '0;
                            if (y == h_last) begin
                                state_n = SINK_DONE;
                                finish  = 1'b1;
                            end else begin
                                y_n = y + DIM_W'(1);
                            end
                        end else begin
                            x_n = x + DIM_W'(1);
                        end
                    end
                end
            end
            SINK_DONE: state_n = SINK_IDLE;
            default:   state_n = SINK_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (reset) begin
            state        <= SINK_IDLE;
            x            <= '0;
            y            <= '0;
            w_last       <= '0;
            h_last       <= '0;
            chk          <= '0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            frame_chksum <= '0;
            err_sof_cnt  <= '0;
            err_eol_cnt  <= '0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            w_last     <= w_last_n;
            h_last     <= h_last_n;
            chk        <= chk_n;
            frame_done <= finish;
            if (finish) begin
                frame_cnt    <= frame_cnt + 16'd1;
                frame_chksum <= chk_n;
            end
            if (sof_err && (err_sof_cnt != '1)) err_sof_cnt <= err_sof_cnt + ERR_W'(1);
            if (eol_err && (err_eol_cnt != '1)) err_eol_cnt <= err_eol_cnt + ERR_W'(1);
        end
    end
endmodule
